// File: rtl/aes_load_ctrl.sv
// Beat-serial plaintext/key loader and single-shot launch controller for the AES core.
// Latency: a register becomes valid on the clock edge of its last beat; start/done/err are registered one-cycle pulses.
// Backpressure: din_valid low stalls a load indefinitely; commands are refused with err while the core runs.
// Build option: define CMD_ABORT_EN so that a non-nop command during a load aborts it.
module aes_load_ctrl #(
  parameter int DIN_W   = 8,
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIN_W-1:0]   din,
  input  logic               din_valid,
  input  logic [1:0]         cmd,
  input  logic               ready,
  output logic [BLOCK_W-1:0] plain,
  output logic [KEY_W-1:0]   key,
  output logic               plain_vld,
  output logic               key_vld,
  output logic               start,
  output logic               done,
  output logic               err
);

  localparam int P_BEATS   = BLOCK_W / DIN_W;
  localparam int K_BEATS   = KEY_W / DIN_W;
  localparam int MAX_BEATS = (P_BEATS > K_BEATS) ? P_BEATS : K_BEATS;
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P_BEATS - 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_BEATS - 1);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PLAIN = 2'b01;
  localparam logic [1:0] CMD_KEY   = 2'b10;
  localparam logic [1:0] CMD_START = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD_P, LOAD_K, WAIT_LO, BUSY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         wcnt, wcnt_nxt;
  logic [BLOCK_W-1:0] plain_nxt;
  logic [KEY_W-1:0]   key_nxt;
  logic               plain_vld_nxt, key_vld_nxt;
  logic               start_nxt, done_nxt, err_nxt;
  logic               abort_req;

  // A command arriving mid-load either aborts the load or is simply ignored.
`ifdef CMD_ABORT_EN
  assign abort_req = (cmd != CMD_NOP);
`else
  assign abort_req = 1'b0;
`endif

  // State, data registers and pulse outputs; reset discards any partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      plain     <= '0;
      key       <= '0;
      plain_vld <= 1'b0;
      key_vld   <= 1'b0;
      start     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wcnt      <= wcnt_nxt;
      plain     <= plain_nxt;
      key       <= key_nxt;
      plain_vld <= plain_vld_nxt;
      key_vld   <= key_vld_nxt;
      start     <= start_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and next-output decode; done takes priority over err so pulses never overlap.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wcnt_nxt      = wcnt;
    plain_nxt     = plain;
    key_nxt       = key;
    plain_vld_nxt = plain_vld;
    key_vld_nxt   = key_vld;
    start_nxt     = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        case (cmd)
          CMD_PLAIN: begin
            state_nxt     = LOAD_P;
            cnt_nxt       = '0;
            plain_vld_nxt = 1'b0;
          end
          CMD_KEY: begin
            state_nxt   = LOAD_K;
            cnt_nxt     = '0;
            key_vld_nxt = 1'b0;
          end
          CMD_START: begin
            if (plain_vld && key_vld && ready) begin
              start_nxt     = 1'b1;
              plain_vld_nxt = 1'b0;
              wcnt_nxt      = '0;
              state_nxt     = WAIT_LO;
            end else begin
              err_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end
      LOAD_P: begin
        if (abort_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else if (din_valid) begin
          plain_nxt = {plain[BLOCK_W-DIN_W-1:0], din};
          if (cnt == P_LAST) begin
            plain_vld_nxt = 1'b1;
            cnt_nxt       = '0;
            state_nxt     = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LOAD_K: begin
        if (abort_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else if (din_valid) begin
          key_nxt = {key[KEY_W-DIN_W-1:0], din};
          if (cnt == K_LAST) begin
            key_vld_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      WAIT_LO: begin
        // A core that never drops ready within four cycles is taken as already finished.
        if (!ready) begin
          state_nxt = BUSY;
        end else if (wcnt == 2'd3) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
        err_nxt = (cmd != CMD_NOP) && !done_nxt;
      end
      BUSY: begin
        if (ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
        err_nxt = (cmd != CMD_NOP) && !ready;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_load_ctrl.sv
// Bench for aes_load_ctrl: two instances (8-bit/128-bit key and 32-bit/256-bit key).
// Expected events are queued by the stimulus; monitors pop and compare on every pulse or valid rise.
// Directed vectors only; every expected value comes from a small shift-register model.
module tb_aes_load_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: DIN_W=8, KEY_W=128
  logic [7:0]   din0;
  logic         dv0, rdy0;
  logic [1:0]   cmd0;
  logic [127:0] plain0, key0;
  logic         pv0, kv0, st0, dn0, er0;

  // instance 1: DIN_W=32, KEY_W=256
  logic [31:0]  din1;
  logic         dv1, rdy1;
  logic [1:0]   cmd1;
  logic [127:0] plain1;
  logic [255:0] key1;
  logic         pv1, kv1, st1, dn1, er1;

  aes_load_ctrl u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .cmd(cmd0), .ready(rdy0),
    .plain(plain0), .key(key0), .plain_vld(pv0), .key_vld(kv0),
    .start(st0), .done(dn0), .err(er0)
  );

  aes_load_ctrl #(.DIN_W(32), .BLOCK_W(128), .KEY_W(256)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .cmd(cmd1), .ready(rdy1),
    .plain(plain1), .key(key1), .plain_vld(pv1), .key_vld(kv1),
    .start(st1), .done(dn1), .err(er1)
  );

  typedef struct packed {
    logic [2:0]   pul;   // {start, done, err}
    logic         pv;
    logic         kv;
    logic [127:0] plain;
    logic [255:0] key;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;

  int total  = 0;
  int passed = 0;

  // reference model state
  logic [127:0] m_plain0 = '0, m_key0 = '0, m_plain1 = '0;
  logic [255:0] m_key1 = '0;
  logic         mpv0 = 1'b0, mkv0 = 1'b0, mpv1 = 1'b0, mkv1 = 1'b0;
  logic         pv0_q = 1'b0, kv0_q = 1'b0, pv1_q = 1'b0, kv1_q = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic push0(input logic [2:0] pul);
    exp_t e;
    e.pul = pul; e.pv = mpv0; e.kv = mkv0; e.plain = m_plain0; e.key = {128'b0, m_key0};
    q0.push_back(e);
  endtask

  task automatic push1(input logic [2:0] pul);
    exp_t e;
    e.pul = pul; e.pv = mpv1; e.kv = mkv1; e.plain = m_plain1; e.key = m_key1;
    q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full 16-beat load on instance 0 (cmd 01 plain, 10 key), beats base..base+15
  task automatic load0(input logic [1:0] c, input logic [7:0] base);
    cmd0 = c;
    tick();
    cmd0 = 2'b00;
    if (c == 2'b01) mpv0 = 1'b0; else mkv0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din0 = base + 8'(i);
      dv0  = 1'b1;
      tick();
      if (c == 2'b01) m_plain0 = {m_plain0[119:0], din0};
      else            m_key0   = {m_key0[119:0], din0};
    end
    dv0 = 1'b0;
    if (c == 2'b01) mpv0 = 1'b1; else mkv0 = 1'b1;
    push0(3'b000);
  endtask

  // monitor for instance 0
  always @(negedge clk) begin
    if (rst) begin
      pv0_q = 1'b0; kv0_q = 1'b0;
    end else begin
      if (st0 || dn0 || er0 || (pv0 && !pv0_q) || (kv0 && !kv0_q)) begin
        if (q0.size() == 0) begin
          total++;
          $display("FAIL u0 unexpected event: start=%0b done=%0b err=%0b pv=%0b kv=%0b, expected no event",
                   st0, dn0, er0, pv0, kv0);
        end else begin
          e0 = q0.pop_front();
          chk("u0 pulses", 256'({st0, dn0, er0}), 256'(e0.pul));
          chk("u0 plain_vld", 256'(pv0), 256'(e0.pv));
          chk("u0 key_vld", 256'(kv0), 256'(e0.kv));
          chk("u0 plain", 256'(plain0), 256'(e0.plain));
          chk("u0 key", 256'(key0), e0.key);
        end
      end
      pv0_q = pv0; kv0_q = kv0;
    end
  end

  // monitor for instance 1
  always @(negedge clk) begin
    if (rst) begin
      pv1_q = 1'b0; kv1_q = 1'b0;
    end else begin
      if (st1 || dn1 || er1 || (pv1 && !pv1_q) || (kv1 && !kv1_q)) begin
        if (q1.size() == 0) begin
          total++;
          $display("FAIL u1 unexpected event: start=%0b done=%0b err=%0b pv=%0b kv=%0b, expected no event",
                   st1, dn1, er1, pv1, kv1);
        end else begin
          e1 = q1.pop_front();
          chk("u1 pulses", 256'({st1, dn1, er1}), 256'(e1.pul));
          chk("u1 plain_vld", 256'(pv1), 256'(e1.pv));
          chk("u1 key_vld", 256'(kv1), 256'(e1.kv));
          chk("u1 plain", 256'(plain1), 256'(e1.plain));
          chk("u1 key", key1, e1.key);
        end
      end
      pv1_q = pv1; kv1_q = kv1;
    end
  end

  initial begin
    din0 = '0; dv0 = 1'b0; cmd0 = 2'b00; rdy0 = 1'b1;
    din1 = '0; dv1 = 1'b0; cmd1 = 2'b00; rdy1 = 1'b1;
    repeat (2) tick();

    // reset state
    chk("rst u0 plain", 256'(plain0), 256'(0));
    chk("rst u0 key", 256'(key0), 256'(0));
    chk("rst u0 flags", 256'({pv0, kv0, st0, dn0, er0}), 256'(0));
    chk("rst u1 key", key1, 256'(0));
    chk("rst u1 flags", 256'({pv1, kv1, st1, dn1, er1}), 256'(0));
    rst = 1'b0;
    tick();

    // key 00..0F then plain 10..1F
    load0(2'b10, 8'h00);
    load0(2'b01, 8'h10);
    tick();
    chk("load key value", 256'(key0), 256'(128'h000102030405060708090a0b0c0d0e0f));
    chk("load plain value", 256'(plain0), 256'(128'h101112131415161718191a1b1c1d1e1f));

    // launch, core busy 10 cycles with a refused plain command mid-run, then done
    rdy0 = 1'b1; cmd0 = 2'b11;
    tick();
    mpv0 = 1'b0;
    push0(3'b100);
    cmd0 = 2'b00; rdy0 = 1'b0;
    repeat (4) tick();
    cmd0 = 2'b01;
    tick();
    push0(3'b001);
    cmd0 = 2'b00;
    repeat (5) tick();
    rdy0 = 1'b1;
    tick();
    push0(3'b010);
    repeat (3) tick();
    chk("key_vld kept after run", 256'(kv0), 256'(1));

    // start with only the key valid is refused
    cmd0 = 2'b11;
    tick();
    push0(3'b001);
    cmd0 = 2'b00;
    tick();

    // key command on the 7th beat of a plain load
    cmd0 = 2'b01;
    tick();
    cmd0 = 2'b00; mpv0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din0 = 8'hA0 + 8'(i);
      dv0  = 1'b1;
      cmd0 = (i == 6) ? 2'b10 : 2'b00;
      tick();
`ifdef CMD_ABORT_EN
      if (i == 6) begin
        push0(3'b001);
        break;
      end
`endif
      m_plain0 = {m_plain0[119:0], din0};
    end
    dv0 = 1'b0; cmd0 = 2'b00;
`ifndef CMD_ABORT_EN
    mpv0 = 1'b1;
    push0(3'b000);
`endif
    tick();

    // fresh plain load, then start while the core is busy is refused
    load0(2'b01, 8'hC0);
    rdy0 = 1'b0; cmd0 = 2'b11;
    tick();
    push0(3'b001);
    cmd0 = 2'b00;
    tick();

    // core never drops ready: done four cycles after start
    rdy0 = 1'b1; cmd0 = 2'b11;
    tick();
    mpv0 = 1'b0;
    push0(3'b100);
    cmd0 = 2'b00;
    repeat (3) tick();
    chk("timeout no early done", 256'(dn0), 256'(0));
    tick();
    push0(3'b010);
    chk("timeout done", 256'(dn0), 256'(1));
    tick();

    // instance 1: 256-bit key over 32-bit beats, gapped every other cycle
    cmd1 = 2'b10;
    tick();
    cmd1 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      din1 = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
      dv1  = 1'b1;
      tick();
      m_key1 = {m_key1[223:0], din1};
      if (i == 6) chk("u1 key_vld before last beat", 256'(kv1), 256'(0));
      if (i == 7) begin
        mkv1 = 1'b1;
        push1(3'b000);
      end
      din1 = 32'hDEADBEEF; dv1 = 1'b0;
      tick();
    end
    chk("u1 key value", key1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    cmd1 = 2'b01;
    tick();
    cmd1 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      din1 = 32'h11111111 * 32'(i + 1);
      dv1  = 1'b1;
      tick();
      m_plain1 = {m_plain1[95:0], din1};
    end
    dv1 = 1'b0;
    mpv1 = 1'b1;
    push1(3'b000);
    tick();

    // reset after 5 plain beats discards everything
    cmd0 = 2'b01;
    tick();
    cmd0 = 2'b00;
    for (int i = 0; i < 5; i++) begin
      din0 = 8'h70 + 8'(i);
      dv0  = 1'b1;
      tick();
    end
    dv0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid-load rst plain", 256'(plain0), 256'(0));
    chk("mid-load rst key", 256'(key0), 256'(0));
    chk("mid-load rst flags", 256'({pv0, kv0, st0, dn0, er0}), 256'(0));
    chk("mid-load rst u1 plain", 256'(plain1), 256'(0));
    tick();
    rst = 1'b0;
    m_plain0 = '0; m_key0 = '0; mpv0 = 1'b0; mkv0 = 1'b0;
    m_plain1 = '0; m_key1 = '0; mpv1 = 1'b0; mkv1 = 1'b0;
    tick();

    // after reset the controller accepts a new load from IDLE
    load0(2'b10, 8'h40);
    repeat (5) tick();

    chk("u0 expected events all seen", 256'(q0.size()), 256'(0));
    chk("u1 expected events all seen", 256'(q1.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
